uart_cmd_rx: RTL
================

# uart_cmd_rx

Serial command front end for the ALU/UART result path. Receives 8N1 UART bytes on `rx` and assembles three-byte commands (header/opcode, operand A, operand B). It presents each command as `cmd_opcode`/`cmd_a`/`cmd_b` with a valid/ack handshake to the execution FSM, which drives the ALU and returns results over UART TX.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range 4..65535.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `ena`  in  1  block enable; low holds receiver and assembler idle.
- `rx`  in  1  asynchronous serial input, idle high.
- `cmd_ack`  in  1  consumer accepts current command.
- `cmd_opcode`  out  3  ALU opcode of latched command.
- `cmd_a`  out  8  operand A.
- `cmd_b`  out  8  operand B.
- `cmd_valid`  out  1  latched command available.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `hdr_err`  out  1  one-cycle pulse: byte 0 header mismatch.
- `overrun`  out  1  one-cycle pulse: command completed while previous one unacked.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1 and run regardless of `ena`. All logic below uses the synchronized value `rxs`.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. Bit index is 0..7.
- Receiver states:
  - IDLE: if `rxs`==0, go to START with counter cleared.
  - START: when counter reaches `CLKS_PER_BIT/2 - 1` (mid start bit), sample `rxs`. If 1, it is a false start: return to IDLE and emit no error. If 0, go to DATA with counter cleared.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles (mid stop bit), sample `rxs`. If 1, deliver the byte to the assembler. If 0, pulse `frame_err`, discard the byte, and reset the assembler index to 0. Go to IDLE in both cases.
- Assembler index `idx` is 0..2.
  - idx 0: byte[7:3] must equal 5'b10101. On a match, hold byte[2:0] as the pending opcode and set idx=1. On a mismatch, pulse `hdr_err` and leave idx at 0. Header bytes therefore fall in 0xA8..0xAF.
  - idx 1: hold the byte as pending A; idx=2.
  - idx 2: byte is B; idx=0, and the command completes.
- Command completion:
  - If `cmd_valid`==0, or `cmd_ack`==1 in the same cycle, load the outputs with the pending opcode/A and the new B, and set `cmd_valid`=1.
  - Otherwise pulse `overrun`, drop the new command, and leave the outputs unchanged.
- `cmd_ack` is only meaningful while `cmd_valid`=1. Ack without a completion clears `cmd_valid` on the next edge. Ack while `cmd_valid`=0 is ignored.
- Outputs `cmd_opcode`/`cmd_a`/`cmd_b` change only on load and are otherwise stable.
- `ena`=0 forces the receiver to IDLE, idx to 0, and `cmd_valid` to 0. Data outputs hold their values and error pulses are 0. When `ena` rises mid-frame, the next low `rxs` is treated as a start bit; header checking resynchronizes.

## Timing
- Reset (`reset_n` low at an edge) sets:
  - `cmd_opcode`=0, `cmd_a`=0, `cmd_b`=0, `cmd_valid`=0, `frame_err`=0, `hdr_err`=0, `overrun`=0
  - receiver in IDLE, idx=0, synchronizer=1, counter=0
- Reset mid-frame abandons the partial byte and command. Reset takes priority over `ena`.
- Input latency: 2 cycles from `rx` to `rxs`.
- Sample points are at cycle offsets `CLKS_PER_BIT/2` + k·`CLKS_PER_BIT` after start detection (k=1..9).
- `cmd_valid` rises on the edge of the byte-2 stop-bit sample. Registered outputs are visible in the following cycle.
- Error pulses are exactly 1 cycle wide, registered, and asserted on the same edge as the relevant sample.
- After the stop sample the receiver returns to IDLE at mid-stop. A start bit arriving immediately after the stop bit is detected without loss, so back-to-back bytes are accepted.
- `cmd_valid` stays high until the edge following a cycle with `cmd_ack`=1 and no simultaneous completion.

## Test plan
All cases use `CLKS_PER_BIT`=16.
- Send 0xAB, 0x12, 0x34 back-to-back → one command with `cmd_opcode`=3, `cmd_a`=0x12, `cmd_b`=0x34, `cmd_valid`=1. Then pulse `cmd_ack` → `cmd_valid`=0 one cycle later; data outputs unchanged.
- Send 0x13, then 0xA8, 0xFF, 0x01 → `hdr_err` pulses once; then a command with op=0, A=0xFF, B=0x01.
- Send 0xA9 followed by a byte with its stop bit driven low → `frame_err` pulses and idx resets. Then send 0xAA, 0x05, 0x06 → op=2, A=5, B=6.
- Two complete commands with no ack → `overrun` pulses at the second completion; outputs keep the first command. A third command whose completion coincides with `cmd_ack`=1 → outputs update and `cmd_valid` stays 1.
- Drive `rx` low for 4 cycles, then high → no state change, no error pulse, idx unchanged.
- Assert `reset_n`=0 during the data bits of byte 1 → all outputs go to 0 at that edge. Then a full command 0xAF, 0x80, 0x7F → op=7, A=0x80, B=0x7F. Repeat the sequence with `ena`=0 → no `cmd_valid`.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// Serial command front end. Receives 8N1 UART bytes on rx and assembles
// three-byte commands (header/opcode, operand A, operand B). Each finished
// command is held on cmd_opcode/cmd_a/cmd_b with a valid/ack handshake.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset
//   ena         block enable; low holds receiver and assembler idle
//   rx          asynchronous serial input, idle high
//   cmd_ack     consumer accepts the current command
//   cmd_opcode  opcode of the latched command (header byte bits 2:0)
//   cmd_a       operand A of the latched command
//   cmd_b       operand B of the latched command
//   cmd_valid   latched command available
//   frame_err   one-cycle pulse: stop bit sampled low
//   hdr_err     one-cycle pulse: first byte of a command is not 0xA8..0xAF
//   overrun     one-cycle pulse: command completed while previous one unacked

module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ena,
    input  logic       rx,
    input  logic       cmd_ack,
    output logic [2:0] cmd_opcode,
    output logic [7:0] cmd_a,
    output logic [7:0] cmd_b,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       hdr_err,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    rx_state_t       state;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [1:0]      idx;
    logic [2:0]      pend_op;
    logic [7:0]      pend_a;

    // Two-flop synchronizer; runs even while disabled so rxs is settled
    // by the time ena rises.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receiver FSM, byte assembler and command handshake in one block so
    // the error pulses and the command load share the stop-sample edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            idx        <= '0;
            pend_op    <= '0;
            pend_a     <= '0;
            cmd_opcode <= '0;
            cmd_a      <= '0;
            cmd_b      <= '0;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
            hdr_err    <= 1'b0;
            overrun    <= 1'b0;
        end else if (!ena) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            idx       <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            hdr_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            hdr_err   <= 1'b0;
            overrun   <= 1'b0;

            // A plain ack drops valid; a load later in this block wins.
            if (cmd_valid && cmd_ack) begin
                cmd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            case (idx)
                                2'd0: begin
                                    if (shreg[7:3] == 5'b10101) begin
                                        pend_op <= shreg[2:0];
                                        idx     <= 2'd1;
                                    end else begin
                                        hdr_err <= 1'b1;
                                    end
                                end
                                2'd1: begin
                                    pend_a <= shreg;
                                    idx    <= 2'd2;
                                end
                                2'd2: begin
                                    idx <= 2'd0;
                                    if (!cmd_valid || cmd_ack) begin
                                        cmd_opcode <= pend_op;
                                        cmd_a      <= pend_a;
                                        cmd_b      <= shreg;
                                        cmd_valid  <= 1'b1;
                                    end else begin
                                        overrun <= 1'b1;
                                    end
                                end
                                default: begin
                                    idx <= 2'd0;
                                end
                            endcase
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
